// File: rtl/gui_pkg.sv
// Shared definitions for the GUI pixel-plotting path: the colour palette,
// the default key-column geometry and the column scheduler state encoding.
package gui_pkg;

  // 3-bit RGB palette used by the plotter
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  // Default key-column geometry: four 40-pixel columns, 120 rows tall
  localparam int DEF_KEY_WIDTH = 40;
  localparam int DEF_SCREEN_H  = 120;

  // Column scheduler states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-request round-robin priority search. The request just after `last`
// has the highest priority, wrapping modulo 4; `last` itself is searched last.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  // cand[k] is the column searched k-th (k = 0 is highest priority)
  logic [1:0] cand [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last + 2'(gi + 1);
    end
  endgenerate

  // Walk from lowest to highest priority so the highest-priority hit wins
  always_comb begin
    grant = 2'd0;
    valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant = cand[k];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_column_scheduler.sv
// Per-column redraw scheduler for the four on-screen key columns. A change
// on any key marks its column dirty; dirty columns are picked round-robin
// and filled as a rectangle through the x/y/colour/plot pixel interface.
module key_column_scheduler
  import gui_pkg::*;
#(
  parameter int         KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int         SCREEN_H       = DEF_SCREEN_H,
  parameter logic [2:0] IDLE_COLOUR    = WHITE,
  parameter logic [2:0] PRESSED_COLOUR = BLUE,
  parameter logic [2:0] DIVIDER_COLOUR = BLACK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys,
  input  logic       hold,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int CXW = $clog2(KEY_WIDTH);
  localparam int CYW = $clog2(SCREEN_H);
  localparam logic [CXW-1:0] CX_LAST = CXW'(KEY_WIDTH - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SCREEN_H - 1);

  state_t         state_reg, state_next;
  logic [3:0]     keys_q_reg;
  logic [3:0]     pending_reg, pending_next;
  logic [3:0]     key_edge;
  logic [3:0]     clear_mask;
  logic [1:0]     last_grant_reg, last_grant_next;
  logic [1:0]     idx_reg, idx_next;
  logic [7:0]     base_reg, base_next;
  logic           pressed_reg, pressed_next;
  logic [CXW-1:0] cx_reg, cx_next;
  logic [CYW-1:0] cy_reg, cy_next;
  logic [7:0]     x_reg, x_next;
  logic [6:0]     y_reg, y_next;
  logic [2:0]     colour_reg, colour_next;
  logic           plot_reg, plot_next;

  logic [1:0]     grant;
  logic           grant_valid;

  rr_arbiter4 u_arbiter (
    .req   (pending_reg),
    .last  (last_grant_reg),
    .grant (grant),
    .valid (grant_valid)
  );

  // Dirty tracking per column: a key edge sets the bit and beats a
  // same-cycle clear, so a column toggled while being loaded is redrawn.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pending
      assign key_edge[gi]     = keys[gi] ^ keys_q_reg[gi];
      assign pending_next[gi] = (pending_reg[gi] & ~clear_mask[gi]) | key_edge[gi];
    end
  endgenerate

  // Next-state and next-output logic for the column fill sequencer
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    idx_next        = idx_reg;
    base_next       = base_reg;
    pressed_next    = pressed_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    colour_next     = colour_reg;
    plot_next       = 1'b0;
    clear_mask      = 4'b0000;

    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (grant_valid) begin
          idx_next          = grant;
          base_next         = 8'(int'(grant) * KEY_WIDTH);
          pressed_next      = keys_q_reg[grant];
          last_grant_next   = grant;
          clear_mask[grant] = 1'b1;
          cx_next           = '0;
          cy_next           = '0;
          state_next        = DRAW;
        end else begin
          state_next = IDLE;
        end
      end

      DRAW: begin
        // hold freezes counters and pixel registers; only the strobe drops
        if (!hold) begin
          x_next    = base_reg + 8'(cx_reg);
          y_next    = 7'(cy_reg);
          plot_next = 1'b1;
          if (cx_reg == CX_LAST && idx_reg != 2'd3) begin
            colour_next = DIVIDER_COLOUR;
          end else if (pressed_reg) begin
            colour_next = PRESSED_COLOUR;
          end else begin
            colour_next = IDLE_COLOUR;
          end

          if (cx_reg == CX_LAST) begin
            cx_next = '0;
            if (cy_reg == CY_LAST) begin
              state_next = IDLE;
            end else begin
              cy_next = cy_reg + CYW'(1);
            end
          end else begin
            cx_next = cx_reg + CXW'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Key sampling, arbitration history, column context and pixel outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keys_q_reg     <= 4'b0000;
      pending_reg    <= 4'b1111;
      last_grant_reg <= 2'd3;
      idx_reg        <= 2'd0;
      base_reg       <= 8'd0;
      pressed_reg    <= 1'b0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      x_reg          <= 8'd0;
      y_reg          <= 7'd0;
      colour_reg     <= 3'd0;
      plot_reg       <= 1'b0;
    end else begin
      keys_q_reg     <= keys;
      pending_reg    <= pending_next;
      last_grant_reg <= last_grant_next;
      idx_reg        <= idx_next;
      base_reg       <= base_next;
      pressed_reg    <= pressed_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      colour_reg     <= colour_next;
      plot_reg       <= plot_next;
    end
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = (state_reg != IDLE) || (|pending_reg);

endmodule

// File: tb/tb_key_column_scheduler.sv
// Directed bench for key_column_scheduler: full post-reset redraw, single
// press, round-robin ordering, re-toggle during own draw, hold, and an
// asynchronous reset in the middle of a column.
module tb_key_column_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic       hold;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  key_column_scheduler dut (
    .clock  (clock),
    .reset  (reset),
    .keys   (keys),
    .hold   (hold),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Follow one column fill from the first plot pulse. Every pixel is compared
  // against the x-major scan model. Optional actions fire right after pixel n
  // is observed: change keys (act_n), hold for 10 cycles (hold_n), or assert
  // reset between clock edges and return (abort_n). -1 disables an action.
  task automatic capture(input string tag, input int exp_idx, input bit exp_pressed,
                         input int exp_lead, input int act_n, input logic [3:0] act_keys,
                         input int hold_n, input int abort_n);
    int lead, gaps, bad, n, ecx, ecy, zeros;
    logic [7:0] ex;
    logic [2:0] ec;
    lead = 0;
    @(negedge clock);
    while (!plot && lead < 50) begin
      lead++;
      @(negedge clock);
    end
    check({tag, "_lead"}, lead, exp_lead);
    if (!plot) return;
    n = 0; gaps = 0; bad = 0;
    while (n < 4800 && gaps < 200) begin
      if (plot) begin
        ecx = n % 40;
        ecy = n / 40;
        ex  = 8'(exp_idx * 40 + ecx);
        ec  = (ecx == 39 && exp_idx != 3) ? 3'b000 : (exp_pressed ? 3'b001 : 3'b111);
        if (x !== ex || y !== 7'(ecy) || colour !== ec) bad++;
        if (n == 0) check({tag, "_first_x"}, x, exp_idx * 40);
        if (hold_n >= 0 && n == hold_n + 1) begin
          check({tag, "_resume_x"}, x, exp_idx * 40 + 6);
          check({tag, "_resume_y"}, y, 7);
        end
        if (n == act_n) keys = act_keys;
        if (n == hold_n) begin
          hold  = 1'b1;
          zeros = 0;
          repeat (10) begin
            @(negedge clock);
            if (!plot) zeros++;
          end
          hold = 1'b0;
          check({tag, "_hold_zeros"}, zeros, 10);
        end
        if (n == abort_n) begin
          #2 reset = 1'b1;
          #1;
          check({tag, "_rst_plot"}, plot, 0);
          check({tag, "_rst_x"}, x, 0);
          check({tag, "_rst_y"}, y, 0);
          check({tag, "_rst_colour"}, colour, 0);
          check({tag, "_rst_busy"}, busy, 1);
          return;
        end
        n++;
      end else begin
        gaps++;
      end
      if (n < 4800) @(negedge clock);
    end
    check({tag, "_pulses"}, n, 4800);
    check({tag, "_bad_pixels"}, bad, 0);
    check({tag, "_gaps"}, gaps, 0);
    $display("column %0d (%s) drawn: pulses=%0d bad=%0d", exp_idx, tag, n, bad);
  endtask

  initial begin
    int plots;
    reset = 1'b0;
    keys  = 4'b0000;
    hold  = 1'b0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset_plot", plot, 0);
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    check("reset_colour", colour, 0);
    check("reset_busy", busy, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Post-reset redraw of all four columns, released colour
    capture("boot0", 0, 1'b0, 2, -1, 4'b0000, -1, -1);
    capture("boot1", 1, 1'b0, 2, -1, 4'b0000, -1, -1);
    capture("boot2", 2, 1'b0, 2, -1, 4'b0000, -1, -1);
    capture("boot3", 3, 1'b0, 2, -1, 4'b0000, -1, -1);
    check("boot_busy_done", busy, 0);
    repeat (5) @(negedge clock);
    check("idle_plot", plot, 0);

    // Single press on column 2
    keys = 4'b0100;
    capture("press2", 2, 1'b1, 3, -1, 4'b0000, -1, -1);
    check("press_busy_done", busy, 0);
    plots = 0;
    repeat (20) begin
      @(negedge clock);
      if (plot) plots++;
    end
    check("press_no_extra", plots, 0);

    // Round-robin: column 1 redraw; keys 0 and 3 toggle mid-draw
    keys = 4'b0110;
    capture("rr1", 1, 1'b1, 3, 100, 4'b1111, -1, -1);
    capture("rr3", 3, 1'b1, 2, -1, 4'b0000, -1, -1);
    capture("rr0", 0, 1'b1, 2, -1, 4'b0000, -1, -1);
    check("rr_busy_done", busy, 0);
    repeat (5) @(negedge clock);

    // Column 2 released, then re-pressed during its own fill
    keys = 4'b1011;
    capture("own2a", 2, 1'b0, 3, 200, 4'b1111, -1, -1);
    capture("own2b", 2, 1'b1, 2, -1, 4'b0000, -1, -1);
    check("own_busy_done", busy, 0);
    repeat (5) @(negedge clock);

    // Hold for 10 cycles after pixel cx=5, cy=7 of column 1
    keys = 4'b1101;
    capture("hold1", 1, 1'b0, 3, -1, 4'b0000, 285, -1);
    check("hold_busy_done", busy, 0);
    repeat (5) @(negedge clock);

    // Asynchronous reset at cy=50 of column 3, then full redraw
    keys = 4'b0101;
    capture("abort3", 3, 1'b0, 3, -1, 4'b0000, -1, 2000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    capture("rb0", 0, 1'b1, 2, -1, 4'b0000, -1, -1);
    capture("rb1", 1, 1'b0, 2, -1, 4'b0000, -1, -1);
    capture("rb2", 2, 1'b1, 2, -1, 4'b0000, -1, -1);
    capture("rb3", 3, 1'b0, 2, -1, 4'b0000, -1, -1);
    check("rb_busy_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
